// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the streaming channel mux.
package stream_mux_pkg;

  typedef enum logic [1:0] {
    ARB_SEL  = 2'd0,
    ARB_PRIO = 2'd1,
    ARB_RR   = 2'd2
  } arb_mode_e;

  // Channel index width; a single channel still gets one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Rotating-priority search: first requester at or after ptr, wrapping at N-1.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = ch_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  localparam int unsigned SW = W + 1;

  logic [SW-1:0] cand;
  logic [W-1:0]  idx;

  // One extra bit so ptr+k never overflows before the wrap subtraction.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = SW'(ptr) + SW'(k);
      if (cand >= SW'(N)) begin
        cand = cand - SW'(N);
      end
      idx = W'(cand);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel packet-aware stream mux with selectable arbitration and a
// single registered output slot.
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_CH       = 4,
  parameter arb_mode_e   ARB_MODE     = ARB_RR,
  parameter bit          LOCK_ON_LAST = 1'b1,
  localparam int unsigned CH_W        = ch_w(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CH_W-1:0]              sel_i,
  input  logic [NUM_CH-1:0]            in_valid_i,
  input  logic [NUM_CH-1:0]            in_last_i,
  input  logic [DATA_WIDTH*NUM_CH-1:0] in_data_i,
  output logic [NUM_CH-1:0]            in_ready_o,
  output logic                         out_valid_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic                         out_last_o,
  output logic [CH_W-1:0]              out_ch_o,
  input  logic                         out_ready_i
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CH_W-1:0] lock_ch_q, lock_ch_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_data[k] = in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Fixed priority is the rotating search with the pointer pinned at 0.
  logic [CH_W-1:0] arb_ptr;
  logic [CH_W-1:0] arb_idx;
  logic            arb_vld;

  assign arb_ptr = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

  rr_arbiter #(
    .N (NUM_CH),
    .W (CH_W)
  ) u_arb (
    .req     (in_valid_i),
    .ptr     (arb_ptr),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  logic            sel_hit;
  logic            slot_free;
  logic [CH_W-1:0] gnt;
  logic            gnt_vld;
  logic            accept;

  assign sel_hit   = (32'(sel_i) < NUM_CH) && in_valid_i[sel_i];
  assign slot_free = !out_valid_o || out_ready_i;

  // Grant, handshake and lock/pointer next-state.
  always_comb begin
    state_d    = state_q;
    lock_ch_d  = lock_ch_q;
    rr_ptr_d   = rr_ptr_q;
    gnt        = '0;
    gnt_vld    = 1'b0;
    in_ready_o = '0;
    accept     = 1'b0;

    if (state_q == LOCKED) begin
      gnt     = lock_ch_q;
      gnt_vld = 1'b1;
    end else if (ARB_MODE == ARB_SEL) begin
      gnt     = sel_i;
      gnt_vld = sel_hit;
    end else begin
      gnt     = arb_idx;
      gnt_vld = arb_vld;
    end

    if (gnt_vld && slot_free && !reset) begin
      in_ready_o[gnt] = 1'b1;
      accept          = in_valid_i[gnt];
    end

    if (accept) begin
      if (LOCK_ON_LAST) begin
        state_d   = in_last_i[gnt] ? IDLE : LOCKED;
        lock_ch_d = gnt;
      end
      if ((ARB_MODE == ARB_RR) && (!LOCK_ON_LAST || in_last_i[gnt])) begin
        rr_ptr_d = (32'(gnt) == NUM_CH - 1) ? '0 : gnt + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      out_ch_o    <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
      if (slot_free) begin
        out_valid_o <= accept;
        if (accept) begin
          out_data_o <= ch_data[gnt];
          out_last_o <= in_last_i[gnt];
          out_ch_o   <= gnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Randomized scoreboard bench: three mux configurations driven side by side
// and checked against a packet-level reference of the arbitration rules.
module tb_stream_mux_arb;
  import stream_mux_pkg::*;

  localparam int DW = 32;
  localparam int NI = 3;
  localparam int MC = 5;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [2:0]    ch;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [MC-1:0]    vld  [NI];
  logic [MC-1:0]    lst  [NI];
  logic [MC*DW-1:0] dat  [NI];
  logic             ordy [NI];
  logic [2:0]       sel;

  logic [3:0]    rdy0, rdy1;
  logic [4:0]    rdy2;
  logic [1:0]    och0, och1;
  logic [2:0]    och2;
  logic          ovld  [NI];
  logic [DW-1:0] odat  [NI];
  logic          olast [NI];
  logic [MC-1:0] rdy   [NI];
  logic [2:0]    och   [NI];

  stream_mux_arb #(.DATA_WIDTH(DW), .NUM_CH(4), .ARB_MODE(ARB_RR), .LOCK_ON_LAST(1'b1)) u_rr (
    .clk(clk), .reset(reset), .sel_i(sel[1:0]),
    .in_valid_i(vld[0][3:0]), .in_last_i(lst[0][3:0]), .in_data_i(dat[0][4*DW-1:0]),
    .in_ready_o(rdy0), .out_valid_o(ovld[0]), .out_data_o(odat[0]), .out_last_o(olast[0]),
    .out_ch_o(och0), .out_ready_i(ordy[0]));

  stream_mux_arb #(.DATA_WIDTH(DW), .NUM_CH(4), .ARB_MODE(ARB_PRIO), .LOCK_ON_LAST(1'b0)) u_prio (
    .clk(clk), .reset(reset), .sel_i(sel[1:0]),
    .in_valid_i(vld[1][3:0]), .in_last_i(lst[1][3:0]), .in_data_i(dat[1][4*DW-1:0]),
    .in_ready_o(rdy1), .out_valid_o(ovld[1]), .out_data_o(odat[1]), .out_last_o(olast[1]),
    .out_ch_o(och1), .out_ready_i(ordy[1]));

  stream_mux_arb #(.DATA_WIDTH(DW), .NUM_CH(5), .ARB_MODE(ARB_SEL), .LOCK_ON_LAST(1'b1)) u_sel (
    .clk(clk), .reset(reset), .sel_i(sel),
    .in_valid_i(vld[2]), .in_last_i(lst[2]), .in_data_i(dat[2]),
    .in_ready_o(rdy2), .out_valid_o(ovld[2]), .out_data_o(odat[2]), .out_last_o(olast[2]),
    .out_ch_o(och2), .out_ready_i(ordy[2]));

  always_comb begin
    rdy[0] = {1'b0, rdy0};
    rdy[1] = {1'b0, rdy1};
    rdy[2] = rdy2;
    och[0] = {1'b0, och0};
    och[1] = {1'b0, och1};
    och[2] = och2;
  end

  // Configuration of each instance as the reference sees it.
  function automatic int nch_of(input int d);
    return (d == 2) ? 5 : 4;
  endfunction
  function automatic int mode_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 0);
  endfunction
  function automatic bit lol_of(input int d);
    return d != 1;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  bit    lk     [NI];
  int    lk_ch  [NI];
  int    ptr    [NI];
  bit    pend_v [NI];
  out_t  pend   [NI];
  beat_t src_q  [NI][MC][$];
  out_t  exp_q  [NI][$];
  bit    rst_edge = 1'b0;

  int pv, max_len, ordy_pct;
  bit ordy_tog;

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, act, req);
    end
  endtask

  task automatic model_reset(input int d);
    lk[d]     = 1'b0;
    lk_ch[d]  = 0;
    ptr[d]    = 0;
    pend_v[d] = 1'b0;
    exp_q[d].delete();
    for (int c = 0; c < MC; c++) src_q[d][c].delete();
  endtask

  task automatic gen_packet(input int d, input int c);
    int    len;
    beat_t b;
    len = $urandom_range(max_len, 1);
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.last = (i == len - 1);
      src_q[d][c].push_back(b);
    end
  endtask

  // Expected grant from the spec rules; -1 means nobody is granted.
  function automatic int exp_grant(input int d, input logic [MC-1:0] v, input int s);
    int n;
    int c;
    n = nch_of(d);
    if (lk[d]) return lk_ch[d];
    if (mode_of(d) == 0) begin
      if (s < n && v[s]) return s;
      return -1;
    end
    for (int k = 0; k < n; k++) begin
      c = (mode_of(d) == 2) ? (ptr[d] + k) % n : k;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    beat_t b;
    if ($urandom_range(99) < 30) sel = 3'($urandom_range(7));
    for (int d = 0; d < NI; d++) begin
      for (int c = 0; c < nch_of(d); c++) begin
        if (src_q[d][c].size() == 0) gen_packet(d, c);
        b = src_q[d][c][0];
        vld[d][c] = ($urandom_range(99) < pv);
        lst[d][c] = b.last;
        dat[d][c*DW +: DW] = b.data;
      end
      ordy[d] = ordy_tog ? ~ordy[d] : ($urandom_range(99) < ordy_pct);
    end
  endtask

  task automatic evaluate();
    int            g;
    bit            sf;
    logic [MC-1:0] erdy;
    beat_t         b;
    for (int d = 0; d < NI; d++) begin
      g    = exp_grant(d, vld[d], int'(sel));
      sf   = (exp_q[d].size() == 0) || ordy[d];
      erdy = '0;
      if (g >= 0 && !reset && sf) erdy[g] = 1'b1;
      chk("in_ready", d, 64'(rdy[d]), 64'(erdy));
      if (erdy != '0 && vld[d][g]) begin
        b            = src_q[d][g].pop_front();
        pend[d].data = b.data;
        pend[d].last = b.last;
        pend[d].ch   = 3'(g);
        pend_v[d]    = 1'b1;
        if (lol_of(d)) begin
          lk[d]    = !b.last;
          lk_ch[d] = g;
        end
        if (mode_of(d) == 2 && (!lol_of(d) || b.last)) ptr[d] = (g + 1) % nch_of(d);
      end
    end
  endtask

  task automatic step(input bit rst_now);
    @(posedge clk);
    #1;
    rst_edge = reset;
    for (int d = 0; d < NI; d++) begin
      if (rst_edge) model_reset(d);
      else if (pend_v[d]) exp_q[d].push_back(pend[d]);
      pend_v[d] = 1'b0;
    end
    reset = rst_now;
    drive_inputs();
    #1;
    evaluate();
  endtask

  // Monitor: compares every presented beat with the scoreboard head.
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < NI; d++) begin
        chk("out_valid", d, 64'(ovld[d]), 64'(exp_q[d].size() != 0));
        if (rst_edge) begin
          chk("rst_data", d, 64'(odat[d]), 64'(0));
          chk("rst_last_ch", d, 64'({olast[d], och[d]}), 64'(0));
        end
        if (exp_q[d].size() != 0) begin
          e = exp_q[d][0];
          if (ovld[d]) begin
            chk("out_data", d, 64'(odat[d]), 64'(e.data));
            chk("out_last", d, 64'(olast[d]), 64'(e.last));
            chk("out_ch", d, 64'(och[d]), 64'(e.ch));
          end
          if (ordy[d]) void'(exp_q[d].pop_front());
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    sel      = '0;
    pv       = 100;
    max_len  = 1;
    ordy_pct = 100;
    ordy_tog = 1'b0;
    for (int d = 0; d < NI; d++) begin
      vld[d]  = '0;
      lst[d]  = '0;
      dat[d]  = '0;
      ordy[d] = 1'b1;
      model_reset(d);
    end
    drive_inputs();

    // Reset held with every channel valid.
    repeat (2) step(1'b1);
    // Single-beat packets, everything valid, no backpressure.
    repeat (20) step(1'b0);
    // Multi-beat packets with valid gaps.
    pv = 60; max_len = 4;
    repeat (80) step(1'b0);
    // Alternating downstream ready.
    pv = 80; max_len = 3; ordy_tog = 1'b1;
    repeat (40) step(1'b0);
    // Fully random traffic and backpressure.
    pv = 70; max_len = 4; ordy_tog = 1'b0; ordy_pct = 70;
    repeat (300) step(1'b0);
    // Reset in the middle of traffic, then resume with all channels valid.
    repeat (2) step(1'b1);
    pv = 100; ordy_pct = 100;
    repeat (150) step(1'b0);
    pv = 0;
    repeat (5) step(1'b0);
    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
